mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/mem_arbiter_arb_pick.sv | 9 +
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encodings and port index constants shared by mem_arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2
    } state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: two-requester winner select; on a tie the port other than last wins
module arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    assign grant[0] = req[0] & (~req[1] | last);
    assign grant[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port to single memory port arbiter (m0 = CPU, m1 = loader/debug).
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise port 0 always wins ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [AW-1:0]   m0_addr,
    input  logic            m0_rstrb,
    input  logic [DW/8-1:0] m0_wmask,
    input  logic [DW-1:0]   m0_wdata,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_done,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_rstrb,
    input  logic [DW/8-1:0] m1_wmask,
    input  logic [DW-1:0]   m1_wdata,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_done,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_rstrb,
    output logic [DW/8-1:0] mem_wmask,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);
    state_t          state, state_n;
    logic            gnt, last;
    logic [1:0]      req, pick;
    logic [DW-1:0]   rdata0_q, rdata1_q;
    logic [DW/8-1:0] sel_wmask;
    logic            sel_rstrb, is_wr, in_access, rd_done, wr_done;

    assign req = {m1_rstrb | (|m1_wmask), m0_rstrb | (|m0_wmask)};

    arb_pick u_pick (.req(req), .last(last), .grant(pick));

    // gnt only changes on a grant, so it doubles as the last-grant pointer
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign last = gnt;
`else
    assign last = PORT1;
`endif

    assign sel_rstrb = (gnt == PORT1) ? m1_rstrb : m0_rstrb;
    assign sel_wmask = (gnt == PORT1) ? m1_wmask : m0_wmask;
    assign is_wr     = |sel_wmask;
    assign in_access = resetn && state == ACCESS;
    assign rd_done   = resetn && state == WAIT_RD;
    assign wr_done   = in_access && is_wr;

    assign mem_addr  = (gnt == PORT1) ? m1_addr : m0_addr;
    assign mem_wdata = (gnt == PORT1) ? m1_wdata : m0_wdata;
    assign mem_rstrb = in_access && sel_rstrb && !is_wr;
    assign mem_wmask = in_access ? sel_wmask : '0;

    assign m0_done  = (wr_done || rd_done) && gnt == PORT0;
    assign m1_done  = (wr_done || rd_done) && gnt == PORT1;
    // read data is forwarded in the done cycle, then held by the port register
    assign m0_rdata = (rd_done && gnt == PORT0) ? mem_rdata : rdata0_q;
    assign m1_rdata = (rd_done && gnt == PORT1) ? mem_rdata : rdata1_q;

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = (|pick) ? ACCESS : IDLE;
            ACCESS:  state_n = is_wr ? IDLE : WAIT_RD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            gnt      <= PORT1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |pick)
                gnt <= pick[1];
            if (rd_done && gnt == PORT0)
                rdata0_q <= mem_rdata;
            if (rd_done && gnt == PORT1)
                rdata1_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (fixed or round-robin build)
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_val;
    logic [3:0]  m0_wmask, m1_wmask, mem_wmask;
    logic        m0_rstrb, m1_rstrb, m0_done, m1_done, mem_rstrb;
    int          checks = 0;
    int          errors = 0;
    int          port, exp_port;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // memory returns mem_val one cycle after the read strobe
    always @(posedge clk)
        if (mem_rstrb) mem_rdata <= mem_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int who);
        who = -1;
        for (int c = 0; c < 8 && who < 0; c++) begin
            @(negedge clk);
            if (m0_done && m1_done) who = 2;
            else if (m0_done) who = 0;
            else if (m1_done) who = 1;
        end
    endtask

    initial begin
        resetn = 1'b0;
        m0_addr = '0; m0_rstrb = 1'b0; m0_wmask = '0; m0_wdata = '0;
        m1_addr = '0; m1_rstrb = 1'b0; m1_wmask = '0; m1_wdata = '0;
        mem_val = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_done", 32'(m0_done), 0);
        check("rst_m1_done", 32'(m1_done), 0);
        check("rst_rstrb", 32'(mem_rstrb), 0);
        check("rst_wmask", 32'(mem_wmask), 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        @(posedge clk); #1 resetn = 1'b1;

        // m0 read: strobe at +1, done with data at +2
        mem_val = 32'h00100093; m0_addr = 32'h10; m0_rstrb = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rd_rstrb", 32'(mem_rstrb), 1);
        check("rd_addr", mem_addr, 32'h10);
        check("rd_wmask", 32'(mem_wmask), 0);
        check("rd_early_done", 32'(m0_done), 0);
        @(posedge clk); @(negedge clk);
        check("rd_rstrb_off", 32'(mem_rstrb), 0);
        check("rd_done", 32'(m0_done), 1);
        check("rd_other_done", 32'(m1_done), 0);
        check("rd_data", m0_rdata, 32'h00100093);
        @(posedge clk); #1 m0_rstrb = 1'b0;
        @(negedge clk);
        check("rd_done_once", 32'(m0_done), 0);
        check("rd_data_hold", m0_rdata, 32'h00100093);

        // m1 full write: done in the access cycle
        m1_addr = 32'h20; m1_wmask = 4'hF; m1_wdata = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        check("wr_wmask", 32'(mem_wmask), 32'hF);
        check("wr_addr", mem_addr, 32'h20);
        check("wr_wdata", mem_wdata, 32'hDEADBEEF);
        check("wr_rstrb", 32'(mem_rstrb), 0);
        check("wr_done", 32'(m1_done), 1);
        check("wr_m0_done", 32'(m0_done), 0);
        check("wr_m0_rdata", m0_rdata, 32'h00100093);
        @(posedge clk); #1 m1_wmask = '0;
        @(negedge clk);
        check("wr_done_once", 32'(m1_done), 0);
        check("wr_wmask_off", 32'(mem_wmask), 0);

        // rstrb with nonzero wmask is a write
        m0_addr = 32'h30; m0_rstrb = 1'b1; m0_wmask = 4'b0011; m0_wdata = 32'h12345678;
        @(posedge clk); @(negedge clk);
        check("mix_rstrb", 32'(mem_rstrb), 0);
        check("mix_wmask", 32'(mem_wmask), 32'h3);
        check("mix_wdata", mem_wdata, 32'h12345678);
        check("mix_done", 32'(m0_done), 1);
        @(posedge clk); #1 m0_rstrb = 1'b0; m0_wmask = '0;
        @(negedge clk);
        check("mix_done_once", 32'(m0_done), 0);
        check("mix_rstrb_idle", 32'(mem_rstrb), 0);

        // reset during WAIT_RD abandons the read
        mem_val = 32'h55AA55AA; m0_addr = 32'h40; m0_rstrb = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rr_rstrb", 32'(mem_rstrb), 1);
        @(posedge clk); #1 resetn = 1'b0;
        @(negedge clk);
        check("rr_no_done0", 32'(m0_done), 0);
        check("rr_no_done1", 32'(m1_done), 0);
        @(posedge clk); #1 resetn = 1'b1; m0_rstrb = 1'b0;
        @(negedge clk);
        check("rr_m0_rdata", m0_rdata, 0);
        check("rr_m1_rdata", m1_rdata, 0);
        check("rr_idle_rstrb", 32'(mem_rstrb), 0);
        check("rr_idle_done", 32'(m0_done), 0);

        // both ports read continuously
        m0_addr = 32'h50; m1_addr = 32'h60; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_val = 32'hC0DE0000 + i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_port = i % 2;
`else
            exp_port = 0;
`endif
            wait_done(port);
            check("tie_port", port, exp_port);
            check("tie_rdata", (port == 1) ? m1_rdata : m0_rdata, 32'hC0DE0000 + i);
        end
        @(posedge clk); #1 m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        repeat (3) @(negedge clk);
        check("end_idle_done", 32'({m1_done, m0_done}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
